dog_anim_ctrl: RTL and testbench

DOG_ANIM_CTRL -- requirements
Module: dog_anim_ctrl

---
 rtl/dog_pkg.sv | 72 +++++++
 rtl/dog_addr_gen.sv | 32 +++
 rtl/dog_anim_ctrl.sv | 159 +++++++++++++++
 tb/tb_dog_anim_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dog_pkg.sv
// Shared types, encodings and constants for the dog sprite animation controller.
package dog_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned SIZE_W  = 7;
  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned FRAME_W = 5;
  localparam int unsigned PIX_W   = 4;
  localparam int unsigned CMD_W   = 2;
  localparam int unsigned CNT_W   = 5;

  // Default hold times, in frame_tick pulses
  localparam int unsigned DEF_STEP_TICKS     = 8;
  localparam int unsigned DEF_SURPRISE_TICKS = 16;
  localparam int unsigned DEF_JUMP_TICKS     = 8;

  typedef enum logic [2:0] {
    ST_WALK      = 3'd0,
    ST_SNIFF     = 3'd1,
    ST_SURPRISED = 3'd2,
    ST_JUMP1     = 3'd3,
    ST_JUMP2     = 3'd4
  } dog_state_t;

  // Behaviour requests; the reserved code behaves as WALK
  localparam logic [CMD_W-1:0] CMD_WALK  = 2'd0;
  localparam logic [CMD_W-1:0] CMD_SNIFF = 2'd1;
  localparam logic [CMD_W-1:0] CMD_JUMP  = 2'd2;
  localparam logic [CMD_W-1:0] CMD_RSVD  = 2'd3;

  // Frame select codes understood by the dog ROM bank
  localparam logic [FRAME_W-1:0] FR_WALK0    = 5'd0;
  localparam logic [FRAME_W-1:0] FR_WALK1    = 5'd1;
  localparam logic [FRAME_W-1:0] FR_WALK2    = 5'd2;
  localparam logic [FRAME_W-1:0] FR_WALK3    = 5'd3;
  localparam logic [FRAME_W-1:0] FR_SNIFF0   = 5'd4;
  localparam logic [FRAME_W-1:0] FR_SNIFF1   = 5'd5;
  localparam logic [FRAME_W-1:0] FR_SURPRISE = 5'd6;
  localparam logic [FRAME_W-1:0] FR_JUMP1    = 5'd7;
  localparam logic [FRAME_W-1:0] FR_JUMP2    = 5'd8;

  // Raster / sprite position
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // State a command asks for when it is accepted
  function automatic dog_state_t cmd_to_state(input logic [CMD_W-1:0] cmd);
    dog_state_t st;
    case (cmd)
      CMD_SNIFF: st = ST_SNIFF;
      CMD_JUMP:  st = ST_SURPRISED;
      default:   st = ST_WALK;
    endcase
    return st;
  endfunction

  // First frame shown when a state is entered
  function automatic logic [FRAME_W-1:0] entry_frame(input dog_state_t st);
    logic [FRAME_W-1:0] f;
    case (st)
      ST_SNIFF:     f = FR_SNIFF0;
      ST_SURPRISED: f = FR_SURPRISE;
      ST_JUMP1:     f = FR_JUMP1;
      ST_JUMP2:     f = FR_JUMP2;
      default:      f = FR_WALK0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/dog_addr_gen.sv
// Combinational sprite hit test and ROM address generation for the dog sprite.
module dog_addr_gen
  import dog_pkg::*;
(
  input  coord_t              draw,
  input  coord_t              dog,
  input  logic [SIZE_W-1:0]   size_x,
  input  logic [SIZE_W-1:0]   size_y,
  output logic                in_sprite_c,
  output logic [ADDR_W-1:0]   addr_c
);

  logic [COORD_W-1:0] rel_x;
  logic [COORD_W-1:0] rel_y;
  logic               x_hit;
  logic               y_hit;

  // Offsets inside the sprite; the >= guards stop a wrapped subtraction from hitting
  always_comb begin
    rel_x       = draw.x - dog.x;
    rel_y       = draw.y - dog.y;
    x_hit       = (draw.x >= dog.x) && (rel_x < COORD_W'(size_x));
    y_hit       = (draw.y >= dog.y) && (rel_y < COORD_W'(size_y));
    in_sprite_c = x_hit && y_hit;
    addr_c      = '0;
    // Inside the sprite both offsets are below 128, so the row-major address fits 14 bits
    if (in_sprite_c) begin
      addr_c = ADDR_W'(rel_y[SIZE_W-1:0]) * ADDR_W'(size_x) + ADDR_W'(rel_x[SIZE_W-1:0]);
    end
  end

endmodule

// File: rtl/dog_anim_ctrl.sv
// Dog sprite animation controller: behaviour FSM paced by frame_tick plus the
// pixel path that turns raster position and ROM data into a palette index.
module dog_anim_ctrl
  import dog_pkg::*;
#(
  parameter int unsigned STEP_TICKS     = DEF_STEP_TICKS,
  parameter int unsigned SURPRISE_TICKS = DEF_SURPRISE_TICKS,
  parameter int unsigned JUMP_TICKS     = DEF_JUMP_TICKS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic [CMD_W-1:0]    cmd,
  input  logic [COORD_W-1:0]  draw_x,
  input  logic [COORD_W-1:0]  draw_y,
  input  logic [COORD_W-1:0]  dog_x,
  input  logic [COORD_W-1:0]  dog_y,
  input  logic [SIZE_W-1:0]   dog_size_x,
  input  logic [SIZE_W-1:0]   dog_size_y,
  input  logic [PIX_W-1:0]    q,
  output logic [FRAME_W-1:0]  frame,
  output logic [ADDR_W-1:0]   address,
  output logic [PIX_W-1:0]    pixel_idx,
  output logic                pixel_valid,
  output logic                busy
);

  dog_state_t          state;
  dog_state_t          state_next;
  dog_state_t          cmd_state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [FRAME_W-1:0]  frame_next;
  logic [FRAME_W-1:0]  walk_adv;
  logic [FRAME_W-1:0]  sniff_adv;
  logic                step_end;
  logic                surprise_end;
  logic                jump_end;
  coord_t              draw_pos;
  coord_t              dog_pos;
  logic                in_sprite_c;
  logic                in_sprite_d;

  // Decoded request and end-of-hold flags for the current tick count
  assign cmd_state    = cmd_to_state(cmd);
  assign step_end     = (cnt == CNT_W'(STEP_TICKS - 1));
  assign surprise_end = (cnt == CNT_W'(SURPRISE_TICKS - 1));
  assign jump_end     = (cnt == CNT_W'(JUMP_TICKS - 1));
  assign walk_adv     = (frame == FR_WALK3) ? FR_WALK0 : frame + FRAME_W'(1);
  assign sniff_adv    = (frame == FR_SNIFF0) ? FR_SNIFF1 : FR_SNIFF0;

  // State, tick counter and frame register; reset wins over any tick
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_WALK;
      cnt   <= '0;
      frame <= FR_WALK0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      frame <= frame_next;
    end
  end

  // Next-state logic; nothing moves between ticks so a video frame keeps one pose
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    frame_next = frame;
    if (frame_tick) begin
      case (state)
        ST_WALK, ST_SNIFF: begin
          if (cmd_state != state) begin
            state_next = cmd_state;
            cnt_next   = '0;
            frame_next = entry_frame(cmd_state);
          end else if (step_end) begin
            cnt_next   = '0;
            frame_next = (state == ST_WALK) ? walk_adv : sniff_adv;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_SURPRISED: begin
          if (surprise_end) begin
            state_next = ST_JUMP1;
            cnt_next   = '0;
            frame_next = FR_JUMP1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_JUMP1: begin
          if (jump_end) begin
            state_next = ST_JUMP2;
            cnt_next   = '0;
            frame_next = FR_JUMP2;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_JUMP2: begin
          if (jump_end) begin
            state_next = ST_WALK;
            cnt_next   = '0;
            frame_next = FR_WALK0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_WALK;
          cnt_next   = '0;
          frame_next = FR_WALK0;
        end
      endcase
    end
  end

  // FSM outputs: the jump sequence locks out new commands
  always_comb begin
    busy = 1'b0;
    case (state)
      ST_SURPRISED, ST_JUMP1, ST_JUMP2: busy = 1'b1;
      default:                          busy = 1'b0;
    endcase
  end

  // Sprite hit test and ROM address for the current raster pixel
  assign draw_pos.x = draw_x;
  assign draw_pos.y = draw_y;
  assign dog_pos.x  = dog_x;
  assign dog_pos.y  = dog_y;

  dog_addr_gen u_addr_gen (
    .draw        (draw_pos),
    .dog         (dog_pos),
    .size_x      (dog_size_x),
    .size_y      (dog_size_y),
    .in_sprite_c (in_sprite_c),
    .addr_c      (address)
  );

  // Delay the hit flag one clock so it lines up with the ROM data
  always_ff @(posedge clock) begin
    if (reset) begin
      in_sprite_d <= 1'b0;
    end else begin
      in_sprite_d <= in_sprite_c;
    end
  end

  // Palette index: index 0 is transparent, outside the sprite is forced transparent
  always_comb begin
    pixel_valid = in_sprite_d && (q != '0);
    pixel_idx   = pixel_valid ? q : '0;
  end

endmodule

// File: tb/tb_dog_anim_ctrl.sv
// Scoreboard bench for dog_anim_ctrl: stimulus queues expected responses,
// a monitor pops and compares them when the matching response is due.
module tb_dog_anim_ctrl;
  import dog_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  logic                frame_tick;
  logic [CMD_W-1:0]    cmd;
  logic [COORD_W-1:0]  draw_x, draw_y, dog_x, dog_y;
  logic [SIZE_W-1:0]   dog_size_x, dog_size_y;
  logic [PIX_W-1:0]    q;
  logic [FRAME_W-1:0]  frame;
  logic [ADDR_W-1:0]   address;
  logic [PIX_W-1:0]    pixel_idx;
  logic                pixel_valid;
  logic                busy;

  always #5 clock = ~clock;

  dog_anim_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .cmd         (cmd),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .dog_x       (dog_x),
    .dog_y       (dog_y),
    .dog_size_x  (dog_size_x),
    .dog_size_y  (dog_size_y),
    .q           (q),
    .frame       (frame),
    .address     (address),
    .pixel_idx   (pixel_idx),
    .pixel_valid (pixel_valid),
    .busy        (busy)
  );

  // ROM model: returns the stimulus-chosen palette value one clock after the address
  logic [PIX_W-1:0] rom_data = '0;
  always @(posedge clock) q <= rom_data;

  typedef struct { int frame; int busy; } anim_exp_t;
  typedef struct { int addr; int idx; int valid; } pix_exp_t;

  anim_exp_t anim_q[$];
  pix_exp_t  pix_q[$];

  logic              anim_chk = 1'b0, pix_chk = 1'b0;
  logic              anim_chk_d = 1'b0, pix_chk_d = 1'b0;
  logic [ADDR_W-1:0] addr_at_edge;

  int n_checks = 0;
  int n_pass   = 0;
  int anim_n   = 0;
  int pix_n    = 0;

  // Strobes mark which cycles owe a response; address is captured at the edge it feeds
  always @(posedge clock) begin
    anim_chk_d   <= anim_chk;
    pix_chk_d    <= pix_chk;
    addr_at_edge <= address;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compares registered outputs half a cycle after the edge
  initial begin
    anim_exp_t a;
    pix_exp_t  p;
    forever begin
      @(negedge clock);
      if (anim_chk_d) begin
        if (anim_q.size() == 0) begin
          n_checks++;
          $display("FAIL anim_underflow: got a response with no queued expectation (t=%0t)", $time);
        end else begin
          a = anim_q.pop_front();
          check($sformatf("frame[%0d]", anim_n), int'(frame), a.frame);
          check($sformatf("busy[%0d]", anim_n), int'(busy), a.busy);
          anim_n++;
        end
      end
      if (pix_chk_d) begin
        if (pix_q.size() == 0) begin
          n_checks++;
          $display("FAIL pix_underflow: got a response with no queued expectation (t=%0t)", $time);
        end else begin
          p = pix_q.pop_front();
          check($sformatf("address[%0d]", pix_n), int'(addr_at_edge), p.addr);
          check($sformatf("pixel_idx[%0d]", pix_n), int'(pixel_idx), p.idx);
          check($sformatf("pixel_valid[%0d]", pix_n), int'(pixel_valid), p.valid);
          pix_n++;
        end
      end
    end
  end

  task automatic push_anim(input int ef, input int eb);
    anim_exp_t e;
    e.frame = ef;
    e.busy  = eb;
    anim_q.push_back(e);
  endtask

  task automatic push_pix(input int ea, input int ei, input int ev);
    pix_exp_t e;
    e.addr  = ea;
    e.idx   = ei;
    e.valid = ev;
    pix_q.push_back(e);
  endtask

  // One tick with cmd c, then an idle cycle with a provocative cmd that must be ignored
  task automatic tick(input logic [CMD_W-1:0] c, input int ef, input int eb);
    cmd = c; frame_tick = 1'b1; anim_chk = 1'b1;
    push_anim(ef, eb);
    @(negedge clock);
    cmd = CMD_JUMP; frame_tick = 1'b0;
    push_anim(ef, eb);
    @(negedge clock);
    anim_chk = 1'b0;
  endtask

  task automatic probe(input int dx, input int dy, input int rom,
                       input int ea, input int ei, input int ev);
    draw_x = COORD_W'(dx); draw_y = COORD_W'(dy); rom_data = PIX_W'(rom);
    pix_chk = 1'b1;
    push_pix(ea, ei, ev);
    @(negedge clock);
    pix_chk = 1'b0;
  endtask

  task automatic set_sprite(input int x, input int y, input int sx, input int sy);
    dog_x = COORD_W'(x); dog_y = COORD_W'(y);
    dog_size_x = SIZE_W'(sx); dog_size_y = SIZE_W'(sy);
  endtask

  // Reset cycle with a tick present: expects WALK/frame 0 and a transparent pixel
  task automatic reset_cycle(input int ea);
    reset = 1'b1; frame_tick = 1'b1; cmd = CMD_JUMP;
    anim_chk = 1'b1; pix_chk = 1'b1;
    push_anim(0, 0);
    push_pix(ea, 0, 0);
    @(negedge clock);
    reset = 1'b0; frame_tick = 1'b0; cmd = CMD_WALK;
    anim_chk = 1'b0; pix_chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion before t=200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; cmd = CMD_WALK;
    draw_x = '0; draw_y = '0;
    set_sprite(0, 0, 0, 0);
    repeat (2) @(negedge clock);
    reset_cycle(0);

    // Walk cycle: frame advances every 8 ticks, reaching frame 2 at tick 48
    for (int k = 1; k <= 48; k++) tick(CMD_WALK, (k / 8) % 4, 0);

    // Switch to sniff at frame 2: frame 4 at once, 5 eight ticks later
    tick(CMD_SNIFF, 4, 0);
    for (int s = 1; s <= 8; s++) tick(CMD_SNIFF, (s < 8) ? 4 : 5, 0);

    // Reserved command behaves as walk
    tick(CMD_RSVD, 0, 0);

    // Jump sequence with sniff requested throughout: 16 x 6, 8 x 7, 8 x 8, then walk
    tick(CMD_JUMP, 6, 1);
    for (int j = 1; j <= 32; j++)
      tick(CMD_SNIFF, (j < 16) ? 6 : (j < 24) ? 7 : (j < 32) ? 8 : 0, (j < 32) ? 1 : 0);
    tick(CMD_SNIFF, 4, 0);

    // Pixel path
    set_sprite(100, 50, 110, 86);
    probe(105,  52, 7,  225, 7, 1);
    probe(210,  52, 7,    0, 0, 0);
    probe(105,  52, 0,  225, 0, 0);
    probe(100,  50, 3,    0, 3, 1);
    probe( 99,  50, 3,    0, 0, 0);
    probe(209, 135, 5, 9459, 5, 1);
    probe(105, 136, 5,    0, 0, 0);
    probe(105,  49, 5,    0, 0, 0);
    set_sprite(0, 0, 127, 127);
    probe(126, 126, 15, 16128, 15, 1);
    probe(127,   0, 15,     0,  0, 0);

    // Reset during JUMP1 with an opaque pixel in flight
    tick(CMD_JUMP, 6, 1);
    for (int j = 1; j <= 18; j++) tick(CMD_WALK, (j < 16) ? 6 : 7, 1);
    set_sprite(100, 50, 110, 86);
    probe(105, 52, 7, 225, 7, 1);
    reset_cycle(225);

    // The reset-cycle tick must not have been counted
    for (int k = 1; k <= 8; k++) tick(CMD_WALK, (k < 8) ? 0 : 1, 0);
    probe(105, 52, 7, 225, 7, 1);

    repeat (3) @(negedge clock);
    check("anim_q_left", anim_q.size(), 0);
    check("pix_q_left", pix_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
